// File: rtl/dspmodem_tx_pkg.sv
// Shared DSPModem transmit-path types, NCO phase constants and arithmetic helpers.
package dspmodem_tx_pkg;

    // Transmit burst state; RAMP_UP/RAMP_DOWN are only reachable with TX_RAMP_EN.
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_RAMP_UP   = 2'd1,
        TX_ACTIVE    = 2'd2,
        TX_RAMP_DOWN = 2'd3
    } tx_state_e;

    // fs/4 carrier phases in quarter cycles.
    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

    // Widest sample sat_neg can handle.
    localparam int unsigned SAT_MAX_W = 64;

    // Saturating negation of a sign-extended width-bit value: the most negative
    // code maps to the most positive one instead of wrapping onto itself.
    function automatic logic signed [SAT_MAX_W-1:0] sat_neg(
        input logic signed [SAT_MAX_W-1:0] x,
        input int unsigned                 width
    );
        logic signed [SAT_MAX_W-1:0] min_v;
        min_v = $signed({SAT_MAX_W{1'b1}} << (width - 1));
        if (x == min_v) begin
            return ~min_v;
        end
        return -x;
    endfunction

endpackage

// File: rtl/tx_ramp_gain.sv
// Burst power ramp: gain counter 0..2**RAMP_LOG2 plus the scaling multiplier.
// Scaling is applied with the gain that accompanies the output being registered.
module tx_ramp_gain
    import dspmodem_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned RAMP_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  tx_state_e               state,
    input  tx_state_e               next_state,
    input  logic signed [WIDTH-1:0] mix_in,
    output logic [RAMP_LOG2:0]      gain,
    output logic signed [WIDTH-1:0] scaled_c
);

    localparam int unsigned GW = RAMP_LOG2 + 1;
    localparam int unsigned PW = WIDTH + RAMP_LOG2 + 1;
    localparam logic [GW-1:0] G_MAX = GW'(1) << RAMP_LOG2;

    logic [GW-1:0]        gain_next;
    logic signed [PW-1:0] prod;

    // Gain follows the state being entered; a fresh burst starts from zero.
    always_comb begin
        gain_next = gain;
        case (next_state)
            TX_IDLE: gain_next = '0;
            TX_RAMP_UP: begin
                if (state == TX_IDLE) begin
                    gain_next = '0;
                end else if (gain != G_MAX) begin
                    gain_next = gain + GW'(1);
                end
            end
            TX_ACTIVE: gain_next = G_MAX;
            TX_RAMP_DOWN: begin
                if (gain != '0) begin
                    gain_next = gain - GW'(1);
                end
            end
            default: gain_next = gain;
        endcase
    end

    // Gain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            gain <= '0;
        end else begin
            gain <= gain_next;
        end
    end

    // Arithmetic scale (m*g)>>>RAMP_LOG2; g = max is an exact pass-through.
    always_comb begin
        prod     = PW'(mix_in) * PW'($signed({1'b0, gain_next}));
        scaled_c = WIDTH'(prod >>> RAMP_LOG2);
    end

endmodule

// File: rtl/fs4_iq_upconverter.sv
// fs/4 quadrature upconverter: baseband I/Q interpolation, fs/4 mixing with
// selectable carrier phase and spectral inversion. Optional burst power ramp
// when the TX_RAMP_EN macro is defined.
module fs4_iq_upconverter
    import dspmodem_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned HOLD_MODE = 1,
    parameter int unsigned RAMP_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sam_clk_ena,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic signed [WIDTH-1:0] in_q,
    input  logic                    tx_en,
    input  logic [1:0]              carrier_phase,
    input  logic                    spec_inv,
    output logic signed [WIDTH-1:0] tx_out,
    output logic                    tx_valid,
    output logic                    busy
);

    tx_state_e               state;
    tx_state_e               next_state;
    logic [1:0]              nco;
    logic [1:0]              cp_lat;
    logic                    si_lat;
    logic [1:0]              cp_eff;
    logic                    si_eff;
    logic [1:0]              phase;
    logic signed [WIDTH-1:0] hold_i;
    logic signed [WIDTH-1:0] hold_q;
    logic                    stuff;
    logic signed [WIDTH-1:0] mix_i;
    logic signed [WIDTH-1:0] mix_q;
    logic signed [WIDTH-1:0] neg_i;
    logic signed [WIDTH-1:0] neg_q;
    logic signed [WIDTH-1:0] mix_c;
    logic signed [WIDTH-1:0] out_c;

`ifdef TX_RAMP_EN
    localparam int unsigned GW = RAMP_LOG2 + 1;
    localparam logic [GW-1:0] G_MAX = GW'(1) << RAMP_LOG2;
    logic [GW-1:0] gain;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
`ifdef TX_RAMP_EN
        case (state)
            TX_IDLE:      if (tx_en) next_state = TX_RAMP_UP;
            TX_RAMP_UP: begin
                if (!tx_en) begin
                    next_state = TX_RAMP_DOWN;
                end else if (gain == G_MAX) begin
                    next_state = TX_ACTIVE;
                end
            end
            TX_ACTIVE:    if (!tx_en) next_state = TX_RAMP_DOWN;
            TX_RAMP_DOWN: begin
                if (tx_en) begin
                    next_state = TX_RAMP_UP;
                end else if (gain == '0) begin
                    next_state = TX_IDLE;
                end
            end
            default:      next_state = TX_IDLE;
        endcase
`else
        case (state)
            TX_IDLE: if (tx_en) next_state = TX_ACTIVE;
            default: if (!tx_en) next_state = TX_IDLE;
        endcase
`endif
    end

    // Baseband capture on every strobe regardless of state; stuff marks the
    // single cycle in which a zero-stuffed sample is presented to the mixer.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_i <= '0;
            hold_q <= '0;
            stuff  <= 1'b0;
        end else begin
            if (sam_clk_ena) begin
                hold_i <= in_i;
                hold_q <= in_q;
            end
            stuff <= sam_clk_ena;
        end
    end

    // NCO holds the phase of the next output sample: 0 while idle so the
    // first burst sample always uses phase cp, then advancing once per clk.
    // Carrier controls track their inputs while idle and freeze for the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            nco    <= PH_0;
            cp_lat <= PH_0;
            si_lat <= 1'b0;
        end else begin
            nco <= (next_state == TX_IDLE) ? PH_0 : nco + 2'd1;
            if (state == TX_IDLE) begin
                cp_lat <= carrier_phase;
                si_lat <= spec_inv;
            end
        end
    end

    // fs/4 mixer: rotate through +Q, +I, -Q, -I with optional Q inversion.
    always_comb begin
        cp_eff = (state == TX_IDLE) ? carrier_phase : cp_lat;
        si_eff = (state == TX_IDLE) ? spec_inv : si_lat;
        phase  = nco + cp_eff;
        mix_i  = ((HOLD_MODE != 0) || stuff) ? hold_i : '0;
        mix_q  = ((HOLD_MODE != 0) || stuff) ? hold_q : '0;
        neg_i  = WIDTH'(sat_neg(SAT_MAX_W'(mix_i), WIDTH));
        neg_q  = WIDTH'(sat_neg(SAT_MAX_W'(mix_q), WIDTH));
        mix_c  = '0;
        case (phase)
            PH_0:    mix_c = si_eff ? neg_q : mix_q;
            PH_1:    mix_c = mix_i;
            PH_2:    mix_c = si_eff ? mix_q : neg_q;
            default: mix_c = neg_i;
        endcase
    end

`ifdef TX_RAMP_EN
    // Burst power ramp on the mixer output.
    tx_ramp_gain #(
        .WIDTH     (WIDTH),
        .RAMP_LOG2 (RAMP_LOG2)
    ) u_ramp (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .next_state (next_state),
        .mix_in     (mix_c),
        .gain       (gain),
        .scaled_c   (out_c)
    );
`else
    // Unity gain (g = max) expressed at the ramp datapath width; reduces to a wire.
    localparam int unsigned PW = WIDTH + RAMP_LOG2 + 1;
    assign out_c = WIDTH'((PW'(mix_c) <<< RAMP_LOG2) >>> RAMP_LOG2);
`endif

    // Output register: zero and invalid whenever the next state is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_out   <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= (next_state != TX_IDLE);
            tx_out   <= (next_state != TX_IDLE) ? out_c : '0;
        end
    end

    assign busy = (state != TX_IDLE);

endmodule
